pipelined_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter with four shift modes, carry-out and zero flags, and valid/ready handshakes on both sides.
- Successor to the single-cycle combinational left/right shifter.
- Sits between the operand-read stage and the ALU write-back path. Handles LSL/LSR/ASR/ROR at any power-of-two width with full backpressure.
- A sideband tag travels with each operation so the consumer can match results to requests.

---
 rtl/pipelined_shifter.sv | 154 +++++++++++++++
 tb/tb_pipelined_shifter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - Pipelined log2 barrel shifter (LSL/LSR/ASR/ROR) with valid/ready handshakes
// Shamt bits are consumed MSB first; the SHAMT_W levels are spread evenly over STAGES register stages.
module pipelined_shifter #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_value,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_carry,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Index k of src_* is the input side of stage k: stage 0 sees the ports, stage k sees stage k-1.
  logic [STAGES-1:0]              st_v;
  logic [STAGES-1:0]              load;
  logic [STAGES-1:0]              src_v;
  logic [STAGES-1:0][WIDTH-1:0]   src_val;
  logic [STAGES-1:0][SHAMT_W-1:0] src_shamt;
  logic [STAGES-1:0][1:0]         src_op;
  logic [STAGES-1:0][TAG_W-1:0]   src_tag;
  logic [STAGES-1:0]              src_cy;

  logic [SHAMT_W-1:0] lsl_idx;
  logic [SHAMT_W-1:0] rsh_idx;
  logic               in_cy;

  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] p,
                                                   input logic [1:0]       op,
                                                   input int               d);
    case (op)
      OP_LSL:  shift_level = p << d;
      OP_LSR:  shift_level = p >> d;
      OP_ASR:  shift_level = $signed(p) >>> d;
      default: shift_level = (p >> d) | (p << (WIDTH - d));
    endcase
  endfunction

  // ROR has no shifted-out bit up front; its carry slot holds "shamt nonzero" until the last stage.
  always_comb begin
    lsl_idx = SHAMT_W'(0) - in_shamt;
    rsh_idx = in_shamt - SHAMT_W'(1);
    case (in_op)
      OP_LSL:  in_cy = in_value[lsl_idx];
      OP_ROR:  in_cy = 1'b1;
      default: in_cy = in_value[rsh_idx];
    endcase
    if (in_shamt == '0)
      in_cy = 1'b0;
  end

  assign src_v[0]     = in_valid;
  assign src_val[0]   = in_value;
  assign src_shamt[0] = in_shamt;
  assign src_op[0]    = in_op;
  assign src_tag[0]   = in_tag;
  assign src_cy[0]    = in_cy;
  assign in_ready     = load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] lvl;
    logic             cy_nxt;
    logic             v_q;
    logic [WIDTH-1:0] val_q;
    logic [TAG_W-1:0] tag_q;
    logic             cy_q;

    // A stage can load if any stage from here to the output has a hole, or the output drains.
    assign load[k] = out_ready || !(&st_v[STAGES-1:k]);
    assign st_v[k] = v_q;

    always_comb begin
      lvl = src_val[k];
      for (int j = 0; j < SHAMT_W; j++) begin
        if (((j * STAGES) / SHAMT_W) == k && src_shamt[k][SHAMT_W-1-j])
          lvl = shift_level(lvl, src_op[k], 1 << (SHAMT_W - 1 - j));
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic zero_q;

      assign cy_nxt = (src_op[k] == OP_ROR) ? (src_cy[k] && lvl[WIDTH-1]) : src_cy[k];

      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          zero_q <= 1'b0;
        else if (load[k] && src_v[k])
          zero_q <= (lvl == '0);
      end

      assign out_valid  = v_q;
      assign out_result = val_q;
      assign out_carry  = cy_q;
      assign out_zero   = zero_q;
      assign out_tag    = tag_q;
    end else begin : g_mid
      logic [SHAMT_W-1:0] shamt_q;
      logic [1:0]         op_q;

      assign cy_nxt = src_cy[k];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          shamt_q <= '0;
          op_q    <= '0;
        end else if (load[k] && src_v[k]) begin
          shamt_q <= src_shamt[k];
          op_q    <= src_op[k];
        end
      end

      assign src_v[k+1]     = v_q;
      assign src_val[k+1]   = val_q;
      assign src_shamt[k+1] = shamt_q;
      assign src_op[k+1]    = op_q;
      assign src_tag[k+1]   = tag_q;
      assign src_cy[k+1]    = cy_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q   <= 1'b0;
        val_q <= '0;
        tag_q <= '0;
        cy_q  <= 1'b0;
      end else if (load[k]) begin
        v_q <= src_v[k];
        if (src_v[k]) begin
          val_q <= lvl;
          tag_q <= src_tag[k];
          cy_q  <= cy_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - Directed self-checking bench for pipelined_shifter
module tb_pipelined_shifter;

  localparam int WIDTH   = 64;
  localparam int SHAMT_W = 6;
  localparam int STAGES  = 2;
  localparam int TAG_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_value;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               out_carry;
  logic               out_zero;
  logic [TAG_W-1:0]   out_tag;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] bp_val [5];
  logic [5:0]  bp_sh  [5];
  logic [1:0]  bp_op  [5];
  logic [63:0] bp_res [5];
  logic        bp_cy  [5];

  always #5 clk = ~clk;

  pipelined_shifter #(
    .WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STAGES(STAGES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_tag(out_tag)
  );

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] op, input logic [63:0] v, input logic [5:0] s,
                        input logic [3:0] t);
    in_op    = op;
    in_value = v;
    in_shamt = s;
    in_tag   = t;
  endtask

  // Called #1 after a rising edge; issues one op with no backpressure and checks latency and fields.
  task automatic run_op(input logic [1:0] op, input logic [63:0] v, input logic [5:0] s,
                        input logic [3:0] t, input logic [63:0] er, input logic ec,
                        input logic ez, input string nm);
    int lat;
    set_in(op, v, s, t);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_value = ~v;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'd2);
    chk({nm, "_result"}, out_result, er);
    chk({nm, "_carry"}, 64'(out_carry), 64'(ec));
    chk({nm, "_zero"}, 64'(out_zero), 64'(ez));
    chk({nm, "_tag"}, 64'(out_tag), 64'(t));
    @(posedge clk); #1;
    chk({nm, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int next_tag;
    int got;

    bp_op[0] = 2'b00; bp_val[0] = 64'h0123456789ABCDEF; bp_sh[0] = 6'd4;
    bp_res[0] = 64'h123456789ABCDEF0; bp_cy[0] = 1'b0;
    bp_op[1] = 2'b01; bp_val[1] = 64'h0123456789ABCDEF; bp_sh[1] = 6'd8;
    bp_res[1] = 64'h000123456789ABCD; bp_cy[1] = 1'b1;
    bp_op[2] = 2'b10; bp_val[2] = 64'h8000000000000010; bp_sh[2] = 6'd4;
    bp_res[2] = 64'hF800000000000001; bp_cy[2] = 1'b0;
    bp_op[3] = 2'b11; bp_val[3] = 64'h0123456789ABCDEF; bp_sh[3] = 6'd16;
    bp_res[3] = 64'hCDEF0123456789AB; bp_cy[3] = 1'b1;
    bp_op[4] = 2'b00; bp_val[4] = 64'hFFFFFFFFFFFFFFFF; bp_sh[4] = 6'd63;
    bp_res[4] = 64'h8000000000000000; bp_cy[4] = 1'b1;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_in(2'b00, 64'h0, 6'd0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_result", out_result, 64'd0);
    chk("reset_out_carry", 64'(out_carry), 64'd0);
    chk("reset_out_zero", 64'(out_zero), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    run_op(2'b00, 64'h00000000000000F1, 6'd4, 4'd3, 64'h0000000000000F10, 1'b0, 1'b0, "lsl_f1");
    run_op(2'b10, 64'h8000000000000000, 6'd63, 4'd1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, "asr_63");
    run_op(2'b01, 64'h8000000000000000, 6'd63, 4'd2, 64'h0000000000000001, 1'b0, 1'b0, "lsr_63");
    run_op(2'b01, 64'h1, 6'd1, 4'd4, 64'h0, 1'b1, 1'b1, "lsr_1");
    run_op(2'b11, 64'h1, 6'd1, 4'd5, 64'h8000000000000000, 1'b1, 1'b0, "ror_1");
    for (int op = 0; op < 4; op++)
      run_op(2'(op), 64'hDEADBEEFCAFEF00D, 6'd0, 4'(op + 8), 64'hDEADBEEFCAFEF00D,
             1'b0, 1'b0, "shamt0");

    // Backpressure: fill with the consumer stalled, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(bp_op[0], bp_val[0], bp_sh[0], 4'd0);
    #1;
    chk("bp_accept0", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    set_in(bp_op[1], bp_val[1], bp_sh[1], 4'd1);
    #1;
    chk("bp_accept1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    set_in(bp_op[2], bp_val[2], bp_sh[2], 4'd2);
    #1;
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stall_valid", 64'(out_valid), 64'd1);
      chk("bp_stall_tag", 64'(out_tag), 64'd0);
      chk("bp_stall_result", out_result, bp_res[0]);
    end

    next_tag  = 2;
    got       = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      logic acc_in;
      if (next_tag < 5) begin
        set_in(bp_op[next_tag], bp_val[next_tag], bp_sh[next_tag], 4'(next_tag));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_drain_valid", 64'(out_valid), 64'd1);
      chk("bp_drain_tag", 64'(out_tag), 64'(got));
      chk("bp_drain_result", out_result, bp_res[got]);
      chk("bp_drain_carry", 64'(out_carry), 64'(bp_cy[got]));
      acc_in = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc_in)
        next_tag++;
      got++;
    end
    chk("bp_drain_count", 64'(got), 64'd5);
    chk("bp_empty_after", 64'(out_valid), 64'd0);

    // Asynchronous reset with two ops in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_in(2'b00, 64'h00000000000000F1, 6'd4, 4'd5);
    @(posedge clk); #1;
    set_in(2'b01, 64'h000000000000FF00, 6'd8, 4'd6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_result", out_result, 64'd0);
    chk("rst_async_tag", 64'(out_tag), 64'd0);
    chk("rst_async_carry", 64'(out_carry), 64'd0);
    chk("rst_async_zero", 64'(out_zero), 64'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end
    run_op(2'b00, 64'h00000000000000F1, 6'd4, 4'd7, 64'h0000000000000F10, 1'b0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
